// File: rtl/rst_domain_a_ingress_fifo.sv
// Domain-A ingress FIFO: valid/ready byte buffer with a post-reset quiesce
// window and a one-cycle synchronous flush. All state clears on rst_domain_a_n.
module rst_domain_a_ingress_fifo #(
  parameter int DATA_W      = 8,
  parameter int DEPTH       = 4,
  parameter int HOLD_CYCLES = 4
) (
  input  logic                     clk_a,
  input  logic                     rst_domain_a_n,
  input  logic                     flush,
  input  logic                     in_valid,
  input  logic [DATA_W-1:0]        in_data,
  output logic                     in_ready,
  output logic                     out_valid,
  output logic [DATA_W-1:0]        out_data,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     hold_active
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam int HW = $clog2(HOLD_CYCLES + 1);

  typedef enum logic [1:0] {
    ST_HOLD  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [HW-1:0]     hold_cnt_q, hold_cnt_d;
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [DATA_W-1:0] mem_q [DEPTH];

  logic full, empty, push, pop;

  // Extra pointer MSB distinguishes full from empty when the index bits match.
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign empty = (wr_ptr_q == rd_ptr_q);

  assign in_ready    = (state_q == ST_RUN) && !full;
  assign out_valid   = (state_q == ST_RUN) && !empty;
  assign hold_active = (state_q == ST_HOLD);
  assign count       = wr_ptr_q - rd_ptr_q;
  assign out_data    = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    state_d    = state_q;
    hold_cnt_d = hold_cnt_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    push       = 1'b0;
    pop        = 1'b0;
    case (state_q)
      ST_HOLD: begin
        if (hold_cnt_q == HW'(HOLD_CYCLES - 1)) begin
          state_d    = ST_RUN;
          hold_cnt_d = '0;
        end else begin
          hold_cnt_d = hold_cnt_q + 1'b1;
        end
      end
      ST_RUN: begin
        if (flush) begin
          // Flush wins over any transfer requested on the same edge.
          state_d  = ST_FLUSH;
          wr_ptr_d = '0;
          rd_ptr_d = '0;
        end else begin
          push = in_valid && in_ready;
          pop  = out_valid && out_ready;
          if (push) wr_ptr_d = wr_ptr_q + 1'b1;
          if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        end
      end
      ST_FLUSH: begin
        state_d  = ST_RUN;
        wr_ptr_d = '0;
        rd_ptr_d = '0;
      end
      default: begin
        state_d    = ST_HOLD;
        hold_cnt_d = '0;
        wr_ptr_d   = '0;
        rd_ptr_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk_a or negedge rst_domain_a_n) begin
    if (!rst_domain_a_n) begin
      state_q    <= ST_HOLD;
      hold_cnt_q <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
    end else begin
      state_q    <= state_d;
      hold_cnt_q <= hold_cnt_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk_a or negedge rst_domain_a_n) begin
    if (!rst_domain_a_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (push) begin
      mem_q[wr_ptr_q[AW-1:0]] <= in_data;
    end
  end

endmodule

// File: tb/tb_rst_domain_a_ingress_fifo.sv
// Bench for rst_domain_a_ingress_fifo: queue-based reference model plus a
// scoreboard monitor that checks every word handed downstream.
module tb_rst_domain_a_ingress_fifo;

  localparam int DATA_W = 8;
  localparam int DEPTH  = 4;
  localparam int HOLD   = 4;

  localparam int PH_HOLD  = 0;
  localparam int PH_RUN   = 1;
  localparam int PH_FLUSH = 2;

  logic              clk_a = 1'b0;
  logic              rst_n;
  logic              flush;
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_ready;
  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic              out_ready;
  logic [2:0]        count;
  logic              hold_active;

  int checks   = 0;
  int failures = 0;

  int m_phase = PH_HOLD;
  int m_hold  = 0;
  int mq[$];
  int sb[$];

  rst_domain_a_ingress_fifo #(
    .DATA_W(DATA_W), .DEPTH(DEPTH), .HOLD_CYCLES(HOLD)
  ) dut (
    .clk_a(clk_a), .rst_domain_a_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .count(count), .hold_active(hold_active)
  );

  always #5 clk_a = ~clk_a;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: occupancy is a plain queue, phase follows the block's rules.
  initial begin
    bit e_ir, e_ov;
    forever begin
      @(negedge clk_a);
      if (!rst_n) begin
        m_phase = PH_HOLD;
        m_hold  = 0;
        mq.delete();
        sb.delete();
        chk("rst_in_ready", int'(in_ready), 0);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_out_data", int'(out_data), 0);
        chk("rst_count", int'(count), 0);
        chk("rst_hold_active", int'(hold_active), 1);
      end else begin
        e_ir = (m_phase == PH_RUN) && (mq.size() < DEPTH);
        e_ov = (m_phase == PH_RUN) && (mq.size() != 0);
        chk("hold_active", int'(hold_active), int'(m_phase == PH_HOLD));
        chk("in_ready", int'(in_ready), int'(e_ir));
        chk("out_valid", int'(out_valid), int'(e_ov));
        chk("count", int'(count), mq.size());
        case (m_phase)
          PH_HOLD: begin
            m_hold++;
            if (m_hold == HOLD) m_phase = PH_RUN;
          end
          PH_RUN: begin
            if (flush) begin
              m_phase = PH_FLUSH;
              mq.delete();
              sb.delete();
            end else begin
              if (e_ov && out_ready) void'(mq.pop_front());
              if (e_ir && in_valid) begin
                mq.push_back(int'(in_data));
                sb.push_back(int'(in_data));
              end
            end
          end
          default: m_phase = PH_RUN;
        endcase
      end
    end
  end

  // Monitor: every word the DUT hands off must match the scoreboard head.
  initial begin
    int exp;
    forever begin
      @(negedge clk_a);
      if (rst_n && out_valid && out_ready && !flush) begin
        if (sb.size() == 0) begin
          chk("unexpected_word", int'(out_data), -1);
        end else begin
          exp = sb.pop_front();
          chk("out_data", int'(out_data), exp);
        end
      end
    end
  end

  task automatic cyc(input logic v, input logic [7:0] d, input logic r, input logic f);
    in_valid  = v;
    in_data   = d;
    out_ready = r;
    flush     = f;
    @(posedge clk_a);
    #1;
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 8'h00, 1'b1, 1'b0);
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    repeat (3) @(posedge clk_a);
    #1;
    rst_n = 1'b1;

    // Valid held through the quiesce window; first accept after edge 4.
    for (int i = 0; i < 6; i++) cyc(1'b1, 8'hA5, 1'b0, 1'b0);
    drain(3);

    // Fill to full, fifth word held off, then drain in order.
    for (int i = 1; i <= 4; i++) cyc(1'b1, 8'(i), 1'b0, 1'b0);
    cyc(1'b1, 8'h05, 1'b0, 1'b0);
    cyc(1'b1, 8'h05, 1'b0, 1'b0);
    cyc(1'b1, 8'h05, 1'b1, 1'b0);
    cyc(1'b1, 8'h05, 1'b1, 1'b0);
    drain(6);

    // Continuous stream with both sides ready.
    for (int i = 0; i < 16; i++) cyc(1'b1, 8'(i), 1'b1, 1'b0);
    drain(3);

    // Flush at count=3 alongside a push and a pop request.
    for (int i = 0; i < 3; i++) cyc(1'b1, 8'(8'h20 + i), 1'b0, 1'b0);
    cyc(1'b1, 8'h2F, 1'b1, 1'b1);
    cyc(1'b1, 8'h30, 1'b1, 1'b0);
    cyc(1'b0, 8'h00, 1'b0, 1'b0);
    drain(3);

    // Flush held high for several cycles.
    for (int i = 0; i < 2; i++) cyc(1'b1, 8'(8'h40 + i), 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) cyc(1'b1, 8'h4F, 1'b1, 1'b1);
    drain(3);

    // Reset asserted between edges with 0x02/0x03 buffered.
    for (int i = 1; i <= 3; i++) cyc(1'b1, 8'(i), 1'b0, 1'b0);
    cyc(1'b0, 8'h00, 1'b1, 1'b0);
    in_valid = 1'b1; in_data = 8'h5A; out_ready = 1'b1;
    #2;
    rst_n = 1'b0;
    @(posedge clk_a);
    @(posedge clk_a);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 7; i++) cyc(1'b1, 8'(8'h60 + i), 1'b1, 1'b0);
    drain(4);

    // Simultaneous push and pop at count=2.
    cyc(1'b1, 8'h10, 1'b0, 1'b0);
    cyc(1'b1, 8'h11, 1'b0, 1'b0);
    cyc(1'b1, 8'h77, 1'b1, 1'b0);
    drain(4);

    // Randomized traffic with occasional flushes.
    for (int i = 0; i < 2000; i++) begin
      cyc(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 2) != 0),
          1'($urandom_range(0, 31) == 0));
    end
    drain(6);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
